// File: rtl/ps2_key_mapper.sv
// ps2_key_mapper
//   Programmable PS/2 keyboard-to-button mapper. Key events from hps_io are
//   queued in a small FIFO. Each event is then compared, one table entry per
//   cycle, against a run-time loaded table of NUM_BTN entries. Every entry
//   that matches sets or clears its own button.
//
//   Optional feature macro: PS2_KEY_MAPPER_AUTOFIRE_EN
//     When defined, an autofire phase generator gates the masked buttons.
//     When undefined, af_mask and af_period are ignored and btn = btn_held.
//
// Ports
//   clk_sys    system clock
//   reset      synchronous, active-high reset
//   ps2_key    [10] toggles on each event, [9] pressed, [8] extended, [7:0] code
//   map_we     table write strobe
//   map_idx    index of the table entry to write
//   map_code   [10] valid, [9] ext wildcard, [8] ext, [7:0] code
//   clr_all    release all buttons, flush the FIFO, abort the scan, clear ovf
//   af_mask    per-button autofire enable
//   af_period  autofire half-period in clk_sys cycles (0 = pass-through)
//   btn        button state, 1 = pressed
//   busy       FIFO non-empty or a scan is running
//   ovf        sticky flag: a key event was dropped because the FIFO was full
module ps2_key_mapper #(
  parameter int NUM_BTN    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_DIV_W   = 20
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [10:0]                ps2_key,
  input  logic                       map_we,
  input  logic [$clog2(NUM_BTN)-1:0] map_idx,
  input  logic [10:0]                map_code,
  input  logic                       clr_all,
  input  logic [NUM_BTN-1:0]         af_mask,
  input  logic [AF_DIV_W-1:0]        af_period,
  output logic [NUM_BTN-1:0]         btn,
  output logic                       busy,
  output logic                       ovf
);

  localparam int IDX_W = $clog2(NUM_BTN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BTN - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  // ---------------------------------------------------------------------------
  // Mapping table
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] tbl_valid_q, tbl_valid_d;
  logic [NUM_BTN-1:0] tbl_wild_q,  tbl_wild_d;
  logic [NUM_BTN-1:0] tbl_ext_q,   tbl_ext_d;
  logic [7:0]         tbl_code_q [NUM_BTN];
  logic [7:0]         tbl_code_d [NUM_BTN];

  always_comb begin
    tbl_valid_d = tbl_valid_q;
    tbl_wild_d  = tbl_wild_q;
    tbl_ext_d   = tbl_ext_q;
    tbl_code_d  = tbl_code_q;
    if (map_we) begin
      tbl_valid_d[map_idx] = map_code[10];
      tbl_wild_d[map_idx]  = map_code[9];
      tbl_ext_d[map_idx]   = map_code[8];
      tbl_code_d[map_idx]  = map_code[7:0];
    end
  end

  // Only the valid bits are reset; the rest of an entry is don't-care until
  // it is written with valid set.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tbl_valid_q <= '0;
    end else begin
      tbl_valid_q <= tbl_valid_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    tbl_wild_q <= tbl_wild_d;
    tbl_ext_q  <= tbl_ext_d;
    tbl_code_q <= tbl_code_d;
  end

  // ---------------------------------------------------------------------------
  // Event capture and FIFO
  // ---------------------------------------------------------------------------
  logic             toggle_prev_q, toggle_prev_d;
  logic [9:0]       fifo_mem_q [FIFO_DEPTH];
  logic [9:0]       fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             ovf_q, ovf_d;

  state_t           state_q, state_d;

  logic toggle_evt;
  logic pop;
  logic push_ok;
  logic drop;

  assign toggle_evt = ps2_key[10] ^ toggle_prev_q;
  assign pop        = (state_q == ST_IDLE) && (fifo_cnt_q != '0) && !clr_all;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_ok    = toggle_evt && !clr_all && ((fifo_cnt_q != FIFO_FULL) || pop);
  assign drop       = toggle_evt && !clr_all && !push_ok;

  // The toggle reference follows ps2_key[10] every cycle, including reset and
  // clr_all cycles, so a discarded toggle is not seen again later.
  assign toggle_prev_d = ps2_key[10];

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    ovf_d      = ovf_q;
    if (clr_all) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem_d[wr_ptr_q] = ps2_key[9:0];
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    toggle_prev_q <= toggle_prev_d;
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    fifo_mem_q <= fifo_mem_d;
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [9:0]         ev_q, ev_d;
  logic [NUM_BTN-1:0] btn_held_q, btn_held_d;
  logic               entry_hit;

  assign entry_hit = tbl_valid_q[idx_q] &&
                     (tbl_code_q[idx_q] == ev_q[7:0]) &&
                     (tbl_wild_q[idx_q] || (tbl_ext_q[idx_q] == ev_q[8]));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ev_d       = ev_q;
    btn_held_d = btn_held_q;
    if (clr_all) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      btn_held_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            ev_d    = fifo_mem_q[rd_ptr_q];
            idx_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (entry_hit) begin
            btn_held_d[idx_q] = ev_q[9];
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ev_q       <= '0;
      btn_held_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ev_q       <= ev_d;
      btn_held_q <= btn_held_d;
    end
  end

  assign busy = (fifo_cnt_q != '0) | (state_q == ST_SCAN);
  assign ovf  = ovf_q;

  // ---------------------------------------------------------------------------
  // Autofire
  // ---------------------------------------------------------------------------
`ifdef PS2_KEY_MAPPER_AUTOFIRE_EN
  logic [AF_DIV_W-1:0] af_cnt_q, af_cnt_d;
  logic                af_phase_q, af_phase_d;

  // Comparing with >= lets a shortened period take effect at once: a counter
  // already past the new limit wraps on the next cycle.
  always_comb begin
    af_cnt_d   = af_cnt_q + 1'b1;
    af_phase_d = af_phase_q;
    if (clr_all || (af_period == '0)) begin
      af_cnt_d   = '0;
      af_phase_d = 1'b1;
    end else if (af_cnt_q >= (af_period - 1'b1)) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  assign btn = btn_held_q & ~(af_mask & {NUM_BTN{~af_phase_q}});
`else
  logic unused_af;
  assign unused_af = ^{af_mask, af_period};
  assign btn       = btn_held_q;
`endif

endmodule

// File: tb/tb_ps2_key_mapper.sv
// tb_ps2_key_mapper
//   Self-checking bench for ps2_key_mapper (NUM_BTN=16, FIFO_DEPTH=4).
//   A reference table and button model compute the expected button vector
//   for every accepted key event; it is queued when the event is driven and
//   popped when the DUT has finished scanning that event.
//   Define PS2_KEY_MAPPER_AUTOFIRE_EN to also exercise the autofire gate.
module tb_ps2_key_mapper;

  localparam int NB = 16;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic [10:0]     ps2_key;
  logic            map_we;
  logic [3:0]      map_idx;
  logic [10:0]     map_code;
  logic            clr_all;
  logic [NB-1:0]   af_mask;
  logic [19:0]     af_period;
  logic [NB-1:0]   btn;
  logic            busy;
  logic            ovf;

  ps2_key_mapper #(
    .NUM_BTN   (NB),
    .FIFO_DEPTH(4),
    .AF_DIV_W  (20)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .map_we   (map_we),
    .map_idx  (map_idx),
    .map_code (map_code),
    .clr_all  (clr_all),
    .af_mask  (af_mask),
    .af_period(af_period),
    .btn      (btn),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int assertions = 0;
  int failures   = 0;

  // Reference model
  logic [NB-1:0] m_valid = '0;
  logic [NB-1:0] m_wild  = '0;
  logic [NB-1:0] m_ext   = '0;
  logic [7:0]    m_code [NB];
  logic [NB-1:0] m_btn   = '0;
  logic [NB-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_apply(input logic pressed, input logic ext, input logic [7:0] code);
    for (int unsigned i = 0; i < NB; i++) begin
      if (m_valid[i] && (m_code[i] == code) && (m_wild[i] || (m_ext[i] == ext)))
        m_btn[i] = pressed;
    end
  endtask

  task automatic write_map(input logic [3:0] idx, input logic [10:0] code);
    map_we   = 1'b1;
    map_idx  = idx;
    map_code = code;
    tick();
    map_we   = 1'b0;
    m_valid[idx] = code[10];
    m_wild[idx]  = code[9];
    m_ext[idx]   = code[8];
    m_code[idx]  = code[7:0];
  endtask

  // Drives one toggle; the edge inside this task is the capture edge E0.
  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code,
                          input bit accept);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
    if (accept) begin
      model_apply(pressed, ext, code);
      exp_q.push_back(m_btn);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy === 1'b1) && (n < 300)) begin
      tick();
      n++;
    end
    assertions++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic check_pop(input string name);
    logic [NB-1:0] exp;
    assertions++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, btn=%h", name, btn);
    end else begin
      exp = exp_q.pop_front();
      if (btn !== exp) begin
        failures++;
        $display("FAIL %s: btn=%h required %h", name, btn, exp);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ps2_key   = 11'h400;
    map_we    = 1'b0;
    map_idx   = '0;
    map_code  = '0;
    clr_all   = 1'b0;
    af_mask   = '0;
    af_period = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    assertions++;
    if (btn !== '0) begin
      failures++;
      $display("FAIL reset_btn: btn=%h required 0000", btn);
    end
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_ovf", ovf, 1'b0);
  endtask

  task automatic test_basic();
    write_map(4'd3, {1'b1, 1'b0, 1'b0, 8'h29});
    send_key(1'b1, 1'b0, 8'h29, 1'b1);
    for (int unsigned cyc = 1; cyc <= 17; cyc++) begin
      tick();
      if (cyc == 4)  check_bit("basic_btn3_before_E5", btn[3], 1'b0);
      if (cyc == 5)  check_bit("basic_btn3_at_E5", btn[3], 1'b1);
      if (cyc == 16) check_bit("basic_busy_E16", busy, 1'b1);
      if (cyc == 17) check_bit("basic_busy_E17", busy, 1'b0);
    end
    check_pop("basic_press");
    send_key(1'b0, 1'b0, 8'h29, 1'b1);
    wait_idle("basic_release");
    check_pop("basic_release");
  endtask

  task automatic test_wildcard();
    write_map(4'd0, {1'b1, 1'b1, 1'b0, 8'h75});
    write_map(4'd5, {1'b1, 1'b0, 1'b0, 8'h75});
    send_key(1'b1, 1'b1, 8'h75, 1'b1);
    wait_idle("wild_ext1");
    check_pop("wild_ext1");
    check_bit("wild_ext1_btn0", btn[0], 1'b1);
    check_bit("wild_ext1_btn5", btn[5], 1'b0);
    send_key(1'b1, 1'b0, 8'h75, 1'b1);
    wait_idle("wild_ext0");
    check_pop("wild_ext0");
    check_bit("wild_ext0_btn5", btn[5], 1'b1);
    send_key(1'b0, 1'b0, 8'h75, 1'b1);
    wait_idle("wild_release");
    check_pop("wild_release");
  endtask

  task automatic test_duplicate();
    write_map(4'd2, {1'b1, 1'b0, 1'b0, 8'h16});
    write_map(4'd9, {1'b1, 1'b0, 1'b0, 8'h16});
    send_key(1'b1, 1'b0, 8'h16, 1'b1);
    wait_idle("dup_press");
    check_pop("dup_press");
    assertions++;
    if (btn !== 16'h0204) begin
      failures++;
      $display("FAIL dup_exact: btn=%h required 0204", btn);
    end
    send_key(1'b0, 1'b0, 8'h16, 1'b1);
    wait_idle("dup_release");
    check_pop("dup_release");
  endtask

  // Six toggles on E0..E5: E1 pops one while pushing, E2..E4 fill the FIFO,
  // so the toggle at E5 is dropped. Event k finishes at edge 17+17k.
  task automatic test_overflow();
    int unsigned cyc;
    send_key(1'b1, 1'b0, 8'h29, 1'b1);
    send_key(1'b1, 1'b0, 8'h16, 1'b1);
    send_key(1'b1, 1'b0, 8'h75, 1'b1);
    send_key(1'b0, 1'b0, 8'h29, 1'b1);
    send_key(1'b1, 1'b0, 8'h11, 1'b1);
    send_key(1'b0, 1'b0, 8'h16, 1'b0);
    check_bit("ovf_set", ovf, 1'b1);
    cyc = 5;
    for (int unsigned k = 0; k < 5; k++) begin
      while (cyc < 17 + 17 * k) begin
        tick();
        cyc++;
      end
      check_pop($sformatf("ovf_evt%0d", k));
    end
    check_bit("ovf_busy_done", busy, 1'b0);
    check_bit("ovf_sticky", ovf, 1'b1);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    m_btn = '0;
    check_bit("clr_ovf", ovf, 1'b0);
    check_bit("clr_busy", busy, 1'b0);
    assertions++;
    if (btn !== '0) begin
      failures++;
      $display("FAIL clr_btn: btn=%h required 0000", btn);
    end
  endtask

  task automatic test_clr_race();
    ps2_key  = {~ps2_key[10], 1'b1, 1'b0, 8'h29};
    clr_all  = 1'b1;
    map_we   = 1'b1;
    map_idx  = 4'd7;
    map_code = {1'b1, 1'b0, 1'b0, 8'h1c};
    tick();
    clr_all = 1'b0;
    map_we  = 1'b0;
    m_valid[7] = 1'b1;
    m_wild[7]  = 1'b0;
    m_ext[7]   = 1'b0;
    m_code[7]  = 8'h1c;
    check_bit("race_busy", busy, 1'b0);
    repeat (20) tick();
    assertions++;
    if (btn !== '0) begin
      failures++;
      $display("FAIL race_btn: btn=%h required 0000", btn);
    end
    send_key(1'b1, 1'b0, 8'h1c, 1'b1);
    wait_idle("race_map_we");
    check_pop("race_map_we");
    send_key(1'b1, 1'b0, 8'h29, 1'b1);
    wait_idle("race_later");
    check_pop("race_later");
  endtask

  task automatic test_reset_midrun();
    reset = 1'b1;
    repeat (2) tick();
    reset   = 1'b0;
    m_valid = '0;
    m_btn   = '0;
    tick();
    assertions++;
    if (btn !== '0) begin
      failures++;
      $display("FAIL midreset_btn: btn=%h required 0000", btn);
    end
    send_key(1'b1, 1'b0, 8'h29, 1'b1);
    wait_idle("midreset_table");
    check_pop("midreset_table");
  endtask

`ifdef PS2_KEY_MAPPER_AUTOFIRE_EN
  task automatic test_autofire();
    logic exp;
    write_map(4'd3, {1'b1, 1'b0, 1'b0, 8'h29});
    send_key(1'b1, 1'b0, 8'h29, 1'b1);
    wait_idle("af_hold");
    check_pop("af_hold");
    af_mask = 16'h0008;
    tick();
    check_bit("af_period0_start", btn[3], 1'b1);
    af_period = 20'd4;
    for (int unsigned k = 0; k < 16; k++) begin
      exp = ((k / 4) % 2) == 0;
      check_bit($sformatf("af_pattern%0d", k), btn[3], exp);
      tick();
    end
    af_period = '0;
    tick();
    for (int unsigned k = 0; k < 8; k++) begin
      check_bit($sformatf("af_passthru%0d", k), btn[3], 1'b1);
      tick();
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wildcard();
    test_duplicate();
    test_overflow();
    test_clr_race();
    test_reset_midrun();
`ifdef PS2_KEY_MAPPER_AUTOFIRE_EN
    test_autofire();
`endif
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
